// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns (SEG[0]=a .. SEG[6]=g)
// and the special nibble codes used by the scan reader.
package seg7_pkg;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] NIB_BLANK = 4'hF;
    localparam logic [3:0] NIB_ERR   = 4'hE;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_t;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational inverse decoder: active-low segment pattern to BCD nibble.
// Blank maps to NIB_BLANK without error; anything unrecognised maps to NIB_ERR.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = NIB_ERR;
        err    = 1'b1;
        case (seg)
            SEG_0:     begin nibble = 4'd0;      err = 1'b0; end
            SEG_1:     begin nibble = 4'd1;      err = 1'b0; end
            SEG_2:     begin nibble = 4'd2;      err = 1'b0; end
            SEG_3:     begin nibble = 4'd3;      err = 1'b0; end
            SEG_4:     begin nibble = 4'd4;      err = 1'b0; end
            SEG_5:     begin nibble = 4'd5;      err = 1'b0; end
            SEG_6:     begin nibble = 4'd6;      err = 1'b0; end
            SEG_7:     begin nibble = 4'd7;      err = 1'b0; end
            SEG_8:     begin nibble = 4'd8;      err = 1'b0; end
            SEG_9:     begin nibble = 4'd9;      err = 1'b0; end
            SEG_BLANK: begin nibble = NIB_BLANK; err = 1'b0; end
            default:   begin nibble = NIB_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a scanned active-low 7-segment bus and hands out
// completed frames over valid/ready; frames arriving while one is pending are dropped.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [0:6]          SEG,
    input  logic [NDIG-1:0]     DIG_N,
    input  logic                READY,
    output logic [4*NDIG-1:0]   BCD,
    output logic [NDIG-1:0]     ERR,
    output logic                VALID,
    output logic                OVERRUN
);

    localparam int              SW      = NDIG + 7;
    localparam logic [NDIG-1:0] DIG_ONE = NDIG'(1);

    logic [SW-1:0]      samp, samp_prev;
    logic [3:0]         cnt, cnt_next;
    logic [NDIG-1:0]    samp_dig, dig_low, cap_mask, seen;
    logic [0:6]         samp_seg;
    logic               hold, dig_onehot, capture, frame_done;
    logic [3:0]         dec_nib;
    logic               dec_err;
    logic [4*NDIG-1:0]  shadow_bcd;
    logic [NDIG-1:0]    shadow_err;
    out_state_t         state, state_next;
    logic               load, overrun_next;

    assign samp_dig   = samp[SW-1:7];
    assign samp_seg   = samp[6:0];
    assign dig_low    = ~samp_dig;
    assign dig_onehot = (dig_low != '0) && ((dig_low & (dig_low - DIG_ONE)) == '0);
    assign hold       = (samp == samp_prev);

    // Capture fires once per hold, on the edge where the run length reaches STABLE.
    always_comb begin
        cnt_next = 4'd1;
        if (hold) begin
            cnt_next = (cnt >= 4'(STABLE)) ? cnt : cnt + 4'd1;
        end
    end

    assign capture    = hold && (cnt == 4'(STABLE - 1)) && dig_onehot;
    assign cap_mask   = capture ? dig_low : '0;
    assign frame_done = &seen;

    seg7_pattern_to_bcd u_dec (
        .seg    (samp_seg),
        .nibble (dec_nib),
        .err    (dec_err)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            samp       <= '0;
            samp_prev  <= '0;
            cnt        <= '0;
            seen       <= '0;
            shadow_bcd <= '0;
            shadow_err <= '0;
        end else begin
            samp      <= {DIG_N, SEG};
            samp_prev <= samp;
            cnt       <= cnt_next;
            seen      <= (frame_done ? '0 : seen) | cap_mask;
            for (int i = 0; i < NDIG; i++) begin
                if (cap_mask[i]) begin
                    shadow_bcd[4*i +: 4] <= dec_nib;
                    shadow_err[i]        <= dec_err;
                end
            end
        end
    end

    // A completed frame is accepted when empty, or when the held frame is taken on the same edge.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        overrun_next = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (frame_done) begin
                    load       = 1'b1;
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (READY) begin
                    if (frame_done) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end else if (frame_done) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_EMPTY;
            BCD     <= '0;
            ERR     <= '0;
            OVERRUN <= 1'b0;
        end else begin
            state   <= state_next;
            OVERRUN <= overrun_next;
            if (load) begin
                BCD <= shadow_bcd;
                ERR <= shadow_err;
            end
        end
    end

    assign VALID = (state == ST_FULL);

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: scans frames on the bus, checks delivered
// frames against a scoreboard queue and spot-checks timing, overrun and reset.
module tb_seg7_scan_reader;

    logic        CLOCK_50;
    logic        RESET_N;
    logic [0:6]  SEG;
    logic [3:0]  DIG_N;
    logic        READY;
    logic [15:0] BCD;
    logic [3:0]  ERR;
    logic        VALID;
    logic        OVERRUN;

    int          errors = 0;
    int          checks = 0;
    logic [19:0] sb[$];

    seg7_scan_reader #(.NDIG(4), .STABLE(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SEG      (SEG),
        .DIG_N    (DIG_N),
        .READY    (READY),
        .BCD      (BCD),
        .ERR      (ERR),
        .VALID    (VALID),
        .OVERRUN  (OVERRUN)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [0:6] segOf(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] digSel(input int i);
        logic [3:0] m;
        m    = 4'b1111;
        m[i] = 1'b0;
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs for the coming edge are already set here, so VALID&&READY means a handshake.
    task automatic tick();
        logic [19:0] item;
        if (VALID === 1'b1 && READY === 1'b1) begin
            checkOutput("sb_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                item = sb.pop_front();
                checkOutput("sb_bcd", 32'(BCD), 32'(item[19:4]));
                checkOutput("sb_err", 32'(ERR), 32'(item[3:0]));
            end
        end
        @(negedge CLOCK_50);
    endtask

    task automatic applyStimulus(input logic [3:0] dig, input logic [0:6] seg, input int n);
        DIG_N = dig;
        SEG   = seg;
        repeat (n) tick();
    endtask

    task automatic scanDigit(input int i, input logic [0:6] seg, input int n);
        applyStimulus(digSel(i), seg, n);
    endtask

    initial begin
        RESET_N = 1'b0;
        READY   = 1'b1;
        DIG_N   = 4'b1111;
        SEG     = 7'b1111111;
        #1;
        checkOutput("rst_bcd", 32'(BCD), 32'h0);
        checkOutput("rst_err", 32'(ERR), 32'h0);
        checkOutput("rst_valid", 32'(VALID), 32'h0);
        checkOutput("rst_overrun", 32'(OVERRUN), 32'h0);
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (3) tick();
        checkOutput("idle_valid", 32'(VALID), 32'h0);

        // Plain frame 4321, VALID exactly one edge after the last capture
        sb.push_back({16'h4321, 4'h0});
        scanDigit(0, segOf(1), 8);
        scanDigit(1, segOf(2), 8);
        scanDigit(2, segOf(3), 8);
        scanDigit(3, segOf(4), 5);
        checkOutput("t1_valid_early", 32'(VALID), 32'h0);
        scanDigit(3, segOf(4), 1);
        checkOutput("t1_valid", 32'(VALID), 32'h1);
        checkOutput("t1_bcd", 32'(BCD), 32'h4321);
        checkOutput("t1_err", 32'(ERR), 32'h0);
        scanDigit(3, segOf(4), 2);
        checkOutput("t1_valid_drop", 32'(VALID), 32'h0);

        // Short glitch on d1 is ignored; the stable 7 captures STABLE+1 edges after it appears
        sb.push_back({16'h8970, 4'h0});
        scanDigit(0, segOf(0), 8);
        scanDigit(2, segOf(9), 8);
        scanDigit(3, segOf(8), 8);
        scanDigit(1, segOf(5), 3);
        scanDigit(1, segOf(7), 5);
        checkOutput("t2_valid_early", 32'(VALID), 32'h0);
        scanDigit(1, segOf(7), 1);
        checkOutput("t2_valid", 32'(VALID), 32'h1);
        checkOutput("t2_bcd", 32'(BCD), 32'h8970);
        scanDigit(1, segOf(7), 2);

        // Illegal pattern and blank
        sb.push_back({16'h1E1F, 4'b0100});
        scanDigit(0, 7'b1111111, 8);
        scanDigit(1, segOf(1), 8);
        scanDigit(3, segOf(1), 8);
        scanDigit(2, 7'b1111110, 6);
        checkOutput("t3_valid", 32'(VALID), 32'h1);
        checkOutput("t3_bcd", 32'(BCD), 32'h1E1F);
        checkOutput("t3_err", 32'(ERR), 32'h4);
        scanDigit(2, 7'b1111110, 2);

        // Back-pressure: second frame dropped with a one-cycle OVERRUN
        READY = 1'b0;
        sb.push_back({16'h1234, 4'h0});
        scanDigit(0, segOf(4), 8);
        scanDigit(1, segOf(3), 8);
        scanDigit(2, segOf(2), 8);
        scanDigit(3, segOf(1), 8);
        checkOutput("t4_valid", 32'(VALID), 32'h1);
        checkOutput("t4_bcd", 32'(BCD), 32'h1234);
        scanDigit(0, segOf(8), 8);
        scanDigit(1, segOf(7), 8);
        scanDigit(2, segOf(6), 8);
        scanDigit(3, segOf(5), 5);
        checkOutput("t4_ovr_before", 32'(OVERRUN), 32'h0);
        scanDigit(3, segOf(5), 1);
        checkOutput("t4_ovr_pulse", 32'(OVERRUN), 32'h1);
        checkOutput("t4_bcd_held", 32'(BCD), 32'h1234);
        scanDigit(3, segOf(5), 1);
        checkOutput("t4_ovr_after", 32'(OVERRUN), 32'h0);
        checkOutput("t4_valid_held", 32'(VALID), 32'h1);
        checkOutput("t4_bcd_held2", 32'(BCD), 32'h1234);
        READY = 1'b1;
        tick();
        READY = 1'b0;
        checkOutput("t4_valid_taken", 32'(VALID), 32'h0);
        READY = 1'b1;

        // Multiple-low and none-low selects never capture
        applyStimulus(4'b1100, segOf(9), 8);
        applyStimulus(4'b1111, segOf(8), 8);
        scanDigit(2, segOf(6), 8);
        scanDigit(3, segOf(0), 8);
        checkOutput("t5_no_frame", 32'(VALID), 32'h0);
        sb.push_back({16'h0623, 4'h0});
        scanDigit(0, segOf(3), 8);
        scanDigit(1, segOf(2), 6);
        checkOutput("t5_valid", 32'(VALID), 32'h1);
        checkOutput("t5_bcd", 32'(BCD), 32'h0623);
        scanDigit(1, segOf(2), 2);

        // Reset mid-frame clears outputs at once and discards the partial frame
        scanDigit(0, segOf(1), 8);
        scanDigit(1, segOf(2), 8);
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("t6_rst_bcd", 32'(BCD), 32'h0);
        checkOutput("t6_rst_err", 32'(ERR), 32'h0);
        checkOutput("t6_rst_valid", 32'(VALID), 32'h0);
        checkOutput("t6_rst_overrun", 32'(OVERRUN), 32'h0);
        DIG_N = digSel(2);
        SEG   = segOf(3);
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        scanDigit(2, segOf(3), 8);
        scanDigit(3, segOf(4), 8);
        checkOutput("t6_partial", 32'(VALID), 32'h0);
        sb.push_back({16'h4365, 4'h0});
        scanDigit(0, segOf(5), 8);
        scanDigit(1, segOf(6), 6);
        checkOutput("t6_valid", 32'(VALID), 32'h1);
        checkOutput("t6_bcd", 32'(BCD), 32'h4365);
        scanDigit(1, segOf(6), 2);

        checkOutput("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
